// File: rtl/zigzag_blok_yerlestirici.sv
// Run-length to (row, col) placement stage between the Huffman decoder and the coefficient buffer.
// Optional zero-fill of skipped positions is enabled with `define ZZ_ZERO_FILL_EN.
module zigzag_blok_yerlestirici #(
   parameter int BLOCK_DIM = 8,
   parameter int DATA_W    = 16,
   parameter int RUN_W     = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [RUN_W-1:0]             hd_run_i,
   input  logic [DATA_W-1:0]            hd_veri_i,
   input  logic                         hd_son_i,
   input  logic                         hd_gecerli_i,
   output logic                         hd_hazir_o,
   output logic [DATA_W-1:0]            ct_veri_o,
   output logic [$clog2(BLOCK_DIM)-1:0] ct_row_o,
   output logic [$clog2(BLOCK_DIM)-1:0] ct_col_o,
   output logic                         ct_son_o,
   output logic                         ct_gecerli_o,
   input  logic                         ct_hazir_i,
   output logic                         hata_o
);

   localparam int AREA   = BLOCK_DIM * BLOCK_DIM;
   localparam int DIM_W  = $clog2(BLOCK_DIM);
   localparam int AREA_W = $clog2(AREA);
   localparam int T_W    = (RUN_W + 1 > AREA_W + 2) ? RUN_W + 1 : AREA_W + 2;

   localparam logic [T_W-1:0]    LAST_T   = T_W'(AREA - 1);
   localparam logic [AREA_W:0]   PTR_ONE  = (AREA_W + 1)'(1);
   localparam logic [AREA_W-1:0] LAST_IDX = AREA_W'(AREA - 1);

   typedef logic [AREA-1:0][2*DIM_W-1:0] zz_tbl_t;

   // Walk anti-diagonals; odd diagonals go down-left, even ones go up-right.
   function automatic zz_tbl_t build_zz();
      zz_tbl_t tbl;
      int      idx;
      int      r;
      int      c;
      tbl = '0;
      idx = 0;
      for (int s = 0; s < 2 * BLOCK_DIM - 1; s++) begin
         for (int k = 0; k < BLOCK_DIM; k++) begin
            r = (s % 2 == 1) ? k : BLOCK_DIM - 1 - k;
            c = s - r;
            if (c >= 0 && c < BLOCK_DIM) begin
               tbl[idx[AREA_W-1:0]] = {r[DIM_W-1:0], c[DIM_W-1:0]};
               idx++;
            end
         end
      end
      return tbl;
   endfunction

   // NOTE: the zigzag table is an elaboration-time constant, so it has no reset.
   localparam zz_tbl_t ZZ = build_zz();

   typedef enum logic [1:0] {
      KABUL  = 2'd0,
      AT     = 2'd1
`ifdef ZZ_ZERO_FILL_EN
      , DOLDUR = 2'd2
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [AREA_W:0]     ptr_q, ptr_d;
   logic                hata_q, hata_d;
   logic [DATA_W-1:0]   veri_q, veri_d;
   logic [DIM_W-1:0]    row_q, row_d;
   logic [DIM_W-1:0]    col_q, col_d;
   logic                son_q, son_d;
   logic                gecerli_q, gecerli_d;

`ifdef ZZ_ZERO_FILL_EN
   logic [AREA_W-1:0]   tgt_q, tgt_d;
   logic [DATA_W-1:0]   val_q, val_d;
   logic                son_in_q, son_in_d;
   logic                tail_q, tail_d;
   logic [AREA_W-1:0]   p_idx;
   logic                ptr_last;
`endif

   logic                out_free;
   logic                accept;
   logic [T_W-1:0]      t;
   logic                ovf;
   logic                t_last;
   logic [AREA_W-1:0]   t_idx;
   logic                load;
   logic [DATA_W-1:0]   ld_veri;
   logic [AREA_W-1:0]   ld_idx;
   logic                ld_son;

   assign out_free   = !gecerli_q || ct_hazir_i;
   assign hd_hazir_o = !rst_i && (state_q == AT || (state_q == KABUL && out_free));
   assign accept     = hd_gecerli_i && hd_hazir_o;
   assign t          = T_W'(ptr_q) + T_W'(hd_run_i);
   assign ovf        = t > LAST_T;
   assign t_last     = t == LAST_T;
   assign t_idx      = t[AREA_W-1:0];
`ifdef ZZ_ZERO_FILL_EN
   assign p_idx      = ptr_q[AREA_W-1:0];
   assign ptr_last   = p_idx == LAST_IDX;
`endif

   always_comb begin
      // NOTE: every value written here gets a default first, so no latch is inferred.
      state_d   = state_q;
      ptr_d     = ptr_q;
      hata_d    = hata_q;
      load      = 1'b0;
      ld_veri   = '0;
      ld_idx    = '0;
      ld_son    = 1'b0;
`ifdef ZZ_ZERO_FILL_EN
      tgt_d     = tgt_q;
      val_d     = val_q;
      son_in_d  = son_in_q;
      tail_d    = tail_q;
`endif

      case (state_q)
         KABUL: begin
            if (accept) begin
`ifdef ZZ_ZERO_FILL_EN
               load = 1'b1;
               if (ovf) begin
                  hata_d   = 1'b1;
                  ld_idx   = p_idx;
                  ld_son   = ptr_last;
                  son_in_d = hd_son_i;
                  if (ptr_last) begin
                     ptr_d   = '0;
                     state_d = hd_son_i ? KABUL : AT;
                  end else begin
                     ptr_d   = ptr_q + PTR_ONE;
                     tail_d  = 1'b1;
                     state_d = DOLDUR;
                  end
               end else if (hd_run_i != '0) begin
                  ld_idx   = p_idx;
                  ptr_d    = ptr_q + PTR_ONE;
                  tgt_d    = t_idx;
                  val_d    = hd_veri_i;
                  son_in_d = hd_son_i;
                  tail_d   = 1'b0;
                  state_d  = DOLDUR;
               end else begin
                  ld_veri = hd_veri_i;
                  ld_idx  = t_idx;
                  ld_son  = t_last;
                  if (t_last) begin
                     ptr_d = '0;
                  end else begin
                     ptr_d = t[AREA_W:0] + PTR_ONE;
                     if (hd_son_i) begin
                        tail_d   = 1'b1;
                        son_in_d = 1'b1;
                        state_d  = DOLDUR;
                     end
                  end
               end
`else
               load = 1'b1;
               if (ovf) begin
                  // Close the block downstream with a zero at the final position.
                  hata_d = 1'b1;
                  ld_idx = LAST_IDX;
                  ld_son = 1'b1;
                  if (hd_son_i) ptr_d = '0;
                  else          state_d = AT;
               end else begin
                  ld_veri = hd_veri_i;
                  ld_idx  = t_idx;
                  ld_son  = hd_son_i || t_last;
                  ptr_d   = (hd_son_i || t_last) ? '0 : t[AREA_W:0] + PTR_ONE;
               end
`endif
            end
         end
`ifdef ZZ_ZERO_FILL_EN
         DOLDUR: begin
            if (out_free) begin
               load   = 1'b1;
               ld_idx = p_idx;
               ld_son = ptr_last;
               if (tail_q || p_idx != tgt_q) begin
                  if (ptr_last) begin
                     ptr_d   = '0;
                     tail_d  = 1'b0;
                     state_d = son_in_q ? KABUL : AT;
                  end else begin
                     ptr_d = ptr_q + PTR_ONE;
                  end
               end else begin
                  ld_veri = val_q;
                  if (ptr_last) begin
                     ptr_d   = '0;
                     state_d = KABUL;
                  end else begin
                     ptr_d = ptr_q + PTR_ONE;
                     if (son_in_q) tail_d = 1'b1;
                     else          state_d = KABUL;
                  end
               end
            end
         end
`endif
         AT: begin
            if (accept && hd_son_i) begin
               ptr_d   = '0;
               state_d = KABUL;
            end
         end
         default: state_d = KABUL;
      endcase

      veri_d    = veri_q;
      row_d     = row_q;
      col_d     = col_q;
      son_d     = son_q;
      gecerli_d = gecerli_q && !ct_hazir_i;
      if (load) begin
         veri_d    = ld_veri;
         row_d     = ZZ[ld_idx][2*DIM_W-1:DIM_W];
         col_d     = ZZ[ld_idx][DIM_W-1:0];
         son_d     = ld_son;
         gecerli_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= KABUL;
         ptr_q     <= '0;
         hata_q    <= 1'b0;
         veri_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         son_q     <= 1'b0;
         gecerli_q <= 1'b0;
`ifdef ZZ_ZERO_FILL_EN
         tgt_q     <= '0;
         val_q     <= '0;
         son_in_q  <= 1'b0;
         tail_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hata_q    <= hata_d;
         veri_q    <= veri_d;
         row_q     <= row_d;
         col_q     <= col_d;
         son_q     <= son_d;
         gecerli_q <= gecerli_d;
`ifdef ZZ_ZERO_FILL_EN
         tgt_q     <= tgt_d;
         val_q     <= val_d;
         son_in_q  <= son_in_d;
         tail_q    <= tail_d;
`endif
      end
   end

   assign ct_veri_o    = veri_q;
   assign ct_row_o     = row_q;
   assign ct_col_o     = col_q;
   assign ct_son_o     = son_q;
   assign ct_gecerli_o = gecerli_q;
   assign hata_o       = hata_q;

endmodule

// File: tb/tb_zigzag_blok_yerlestirici.sv
// Scoreboard bench for zigzag_blok_yerlestirici (BLOCK_DIM=8); follows ZZ_ZERO_FILL_EN if defined.
module tb_zigzag_blok_yerlestirici;

   localparam int AREA = 64;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [3:0]  hd_run_i = '0;
   logic [15:0] hd_veri_i = '0;
   logic        hd_son_i = 1'b0;
   logic        hd_gecerli_i = 1'b0;
   logic        hd_hazir_o;
   logic [15:0] ct_veri_o;
   logic [2:0]  ct_row_o;
   logic [2:0]  ct_col_o;
   logic        ct_son_o;
   logic        ct_gecerli_o;
   logic        ct_hazir_i = 1'b1;
   logic        hata_o;

   zigzag_blok_yerlestirici #(.BLOCK_DIM(8), .DATA_W(16), .RUN_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .hd_run_i(hd_run_i), .hd_veri_i(hd_veri_i), .hd_son_i(hd_son_i),
      .hd_gecerli_i(hd_gecerli_i), .hd_hazir_o(hd_hazir_o),
      .ct_veri_o(ct_veri_o), .ct_row_o(ct_row_o), .ct_col_o(ct_col_o),
      .ct_son_o(ct_son_o), .ct_gecerli_o(ct_gecerli_o), .ct_hazir_i(ct_hazir_i),
      .hata_o(hata_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [15:0] veri;
      logic [2:0]  row;
      logic [2:0]  col;
      logic        son;
   } beat_t;

   beat_t      exp_q[$];
   int         total = 0;
   int         bad = 0;
   logic [2:0] m_row[AREA];
   logic [2:0] m_col[AREA];
   int         m_ptr = 0;
   bit         m_drop = 1'b0;
   bit         m_hata = 1'b0;
   int         ready_mode = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Zigzag index of each cell: cells on earlier anti-diagonals, plus those ahead on its own diagonal.
   function automatic void build_model();
      int d, base, pos;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            d = r + c; base = 0; pos = 0;
            for (int rr = 0; rr < 8; rr++) begin
               for (int cc = 0; cc < 8; cc++) begin
                  if (rr + cc < d) base++;
                  else if (rr + cc == d && ((d % 2 == 1) ? rr < r : rr > r)) pos++;
               end
            end
            m_row[base + pos] = 3'(r);
            m_col[base + pos] = 3'(c);
         end
      end
   endfunction

   task automatic push(input logic [15:0] v, input int idx, input bit son);
      exp_q.push_back('{veri: v, row: m_row[idx], col: m_col[idx], son: son});
   endtask

   task automatic model_beat(input int run, input logic [15:0] val, input bit son);
      int t;
      if (m_drop) begin
         if (son) begin m_ptr = 0; m_drop = 1'b0; end
         return;
      end
      t = m_ptr + run;
`ifdef ZZ_ZERO_FILL_EN
      if (t > AREA - 1) begin
         m_hata = 1'b1;
         for (int i = m_ptr; i < AREA; i++) push(16'h0, i, i == AREA - 1);
         m_ptr  = 0;
         m_drop = !son;
      end else begin
         for (int i = m_ptr; i < t; i++) push(16'h0, i, 1'b0);
         push(val, t, t == AREA - 1);
         if (t == AREA - 1) m_ptr = 0;
         else if (son) begin
            for (int i = t + 1; i < AREA; i++) push(16'h0, i, i == AREA - 1);
            m_ptr = 0;
         end else m_ptr = t + 1;
      end
`else
      if (t > AREA - 1) begin
         m_hata = 1'b1;
         push(16'h0, AREA - 1, 1'b1);
         if (son) m_ptr = 0;
         else     m_drop = 1'b1;
      end else begin
         push(val, t, son || t == AREA - 1);
         m_ptr = (son || t == AREA - 1) ? 0 : t + 1;
      end
`endif
   endtask

   task automatic send(input int run, input logic [15:0] val, input bit son);
      bit acc;
      int n;
      n = 0;
      @(negedge clk_i);
      hd_run_i = 4'(run); hd_veri_i = val; hd_son_i = son; hd_gecerli_i = 1'b1;
      forever begin
         #4 acc = hd_hazir_o;
         @(posedge clk_i);
         if (acc) break;
         n++;
         if (n > 500) begin
            total++; bad++;
            $display("FAIL accept_timeout: beat not taken after %0d cycles", n);
            break;
         end
         @(negedge clk_i);
      end
      if (acc) model_beat(run, val, son);
      #1;
      hd_gecerli_i = 1'b0;
      check("hata", 32'(hata_o), 32'(m_hata));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ct_gecerli_o) && n < 5000) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 5000) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1; hd_gecerli_i = 1'b0;
      #1 check("hazir_in_reset", 32'(hd_hazir_o), 0);
      @(posedge clk_i);
      #1 check("reset_outputs", 32'({ct_veri_o, ct_row_o, ct_col_o, ct_son_o, ct_gecerli_o, hata_o}), 0);
      exp_q.delete();
      m_ptr = 0; m_drop = 1'b0; m_hata = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1 check("hazir_after_reset", 32'(hd_hazir_o), 1);
   endtask

   // Monitor: owns ct_hazir_i, pops and compares on every output handshake.
   initial begin
      beat_t got, want, held;
      bit    prev_stall;
      prev_stall = 1'b0;
      held = '0;
      forever begin
         @(negedge clk_i);
         ct_hazir_i = (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
         #4;
         got = '{veri: ct_veri_o, row: ct_row_o, col: ct_col_o, son: ct_son_o};
         if (rst_i) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) check("hold_stable", 32'(got), 32'(held));
            if (ct_gecerli_o && ct_hazir_i) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_beat: got %h with empty scoreboard", got);
               end else begin
                  want = exp_q.pop_front();
                  check("ct_beat", 32'(got), 32'(want));
               end
            end
            prev_stall = ct_gecerli_o && !ct_hazir_i;
            held = got;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      build_model();
      do_reset();

      // Basic placement, then a closing beat at (0,0) proves the pointer wrapped.
      send(0, 16'd5, 1'b0);
      send(0, -16'sd3, 1'b0);
      send(2, 16'd7, 1'b1);
      send(0, 16'd11, 1'b1);
      drain();

      // Output stalled for three cycles while a second beat waits.
      ready_mode = 2;
      send(0, 16'd21, 1'b0);
      fork
         send(0, 16'd22, 1'b0);
         begin
            repeat (3) begin
               @(negedge clk_i);
               #2;
               check("stall_hazir", 32'(hd_hazir_o), 0);
               check("stall_valid", 32'(ct_gecerli_o), 1);
            end
            ready_mode = 0;
         end
      join
      send(0, 16'd23, 1'b1);
      drain();

      // 64 run-0 beats close the block on their own; the 65th starts a new one.
      for (int i = 0; i < 65; i++) send(0, 16'($urandom), 1'b0);
      send(0, 16'd1, 1'b1);
      drain();

      // Overflow from index 60, two dropped beats, a consumed son beat, then a fresh block.
      for (int i = 0; i < 60; i++) send(0, 16'(i + 100), 1'b0);
      send(5, 16'd9, 1'b0);
      send(0, 16'd31, 1'b0);
      send(1, 16'd32, 1'b0);
      send(0, 16'd33, 1'b1);
      send(0, 16'd34, 1'b1);
      drain();
      check("hata_sticky", 32'(hata_o), 1);

      // Reset while an output (or zero-fill) is pending, then a clean restart.
      ready_mode = 2;
      send(3, 16'd7, 1'b1);
      do_reset();
      ready_mode = 0;
      send(0, 16'd4, 1'b0);
      drain();

      // Randomised beats with random downstream back-pressure.
      for (int i = 0; i < 400; i++) begin
         int run;
         run = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
         send(run, 16'($urandom), $urandom_range(0, 7) == 0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/zigzag_blok_yerlestirici.md
# zigzag_blok_yerlestirici

Parametrised run-length-to-coordinate stage sitting between the Huffman decoder (`hd_*`) and the coefficient/IDCT buffer (`ct_*`). Each accepted beat is a (run, coefficient) pair. The block advances a zigzag pointer by `run+1` and emits the coefficient with its (row, col) inside a `BLOCK_DIM`×`BLOCK_DIM` block. It also marks block end, detects run overflow, and (optionally) emits explicit zeros for every skipped position.

## Interface
- `BLOCK_DIM`, 8: block edge; power of two, 2..16. `AREA = BLOCK_DIM*BLOCK_DIM`; `DIM_W = log2(BLOCK_DIM)`; `AREA_W = log2(AREA)`.
- `DATA_W`, 16: signed coefficient width.
- `RUN_W`, 4: zero-run field width.
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `hd_run_i` in `RUN_W`: zeros preceding this coefficient.
- `hd_veri_i` in `DATA_W`: coefficient value.
- `hd_son_i` in 1: beat is the last of its block; qualified by `hd_gecerli_i`.
- `hd_gecerli_i` in 1: input valid.
- `hd_hazir_o` out 1: input ready.
- `ct_veri_o` out `DATA_W`: coefficient value.
- `ct_row_o` out `DIM_W`: row of coefficient.
- `ct_col_o` out `DIM_W`: column of coefficient.
- `ct_son_o` out 1: last output beat of the block.
- `ct_gecerli_o` out 1: output valid.
- `ct_hazir_i` in 1: output ready.
- `hata_o` out 1: sticky run-overflow flag.

## Operation
- Zigzag table is built at elaboration by a constant function for any `BLOCK_DIM`; for 8 it is the standard JPEG order (idx 2 → row 1, col 0).
- `ptr` (width `AREA_W+1`) is the next zigzag index. Target is `t = ptr + run`, computed at `AREA_W+2` bits with no truncation.
- States:
  - **KABUL**: accept beats.
  - **DOLDUR**: zero-fill only.
  - **AT**: drop beats after an overflow.
- Normal accept in KABUL with `t <= AREA-1`:
  - Emit (`veri`, `zz[t]`); `ptr <= t+1`.
  - `ct_son_o = hd_son_i || (t == AREA-1)`.
  - When the beat ends the block, `ptr <= 0` (wrap). Reaching index `AREA-1` without `hd_son_i` also ends the block; the next beat starts a new block at `ptr` 0.
- Overflow in KABUL (`t > AREA-1`):
  - `hata_o <= 1`; the coefficient is discarded.
  - Emit a zero at `zz[AREA-1]` with `ct_son_o=1`, so downstream always closes the block.
  - Go to AT, unless the overflow beat had `hd_son_i`, in which case `ptr <= 0` and stay in KABUL.
- AT:
  - `hd_hazir_o = 1`; beats are consumed and nothing is emitted.
  - A beat with `hd_son_i` → `ptr <= 0`, KABUL.
- `hata_o` clears only on reset.
- Output register:
  - Holds all `ct_*` stable while `ct_gecerli_o && !ct_hazir_i`.
  - `ct_gecerli_o` clears on a handshake unless a new beat loads in the same cycle.

## Timing
- Reset (`rst_i` high at an edge) sets after that edge:
  - `ct_veri_o=0`, `ct_row_o=0`, `ct_col_o=0`, `ct_son_o=0`, `ct_gecerli_o=0`, `hata_o=0`.
  - `ptr=0`, state KABUL.
- While `rst_i` is high, `hd_hazir_o=0`. Reset mid-fill or mid-drop aborts immediately.
- `hd_hazir_o = !rst_i && (state==AT || (state==KABUL && (!ct_gecerli_o || ct_hazir_i)))`. This is a combinational path from `ct_hazir_i`.
- Latency: a beat accepted at edge k is visible on `ct_*` after edge k.
- Throughput: 1 beat/cycle without fill.
- Simultaneous output handshake and input accept in one cycle is legal and loses nothing.
- `run=0` with `ptr=AREA-1` is a normal final beat, not an overflow.

## Configuration
- `ZZ_ZERO_FILL_EN` defined:
  - On accept with `run>0`, the beat is latched. DOLDUR emits zeros at `zz[ptr]..zz[t-1]`, one per output handshake, then the coefficient at `zz[t]`.
  - If the beat had `hd_son_i` and `t < AREA-1`, DOLDUR continues with zeros through `zz[AREA-1]`; `ct_son_o` is set only on index `AREA-1`.
  - On overflow, zeros run from `zz[ptr]` to `zz[AREA-1]` (last one `ct_son_o`), then AT.
  - `hd_hazir_o=0` in DOLDUR. Every block yields exactly `AREA` output beats.
- `ZZ_ZERO_FILL_EN` undefined: DOLDUR does not exist; only nonzero positions are emitted, as in Operation.

## Test plan
- No fill, `BLOCK_DIM=8`, beats (0,5), (0,-3), (2,7,son) → (r0,c0,5), (r0,c1,-3), (r1,c1,7,son); `ptr` returns to 0.
- `ct_hazir_i` low for 3 cycles with the output pending → `ct_*` stable, `hd_hazir_o=0`, all beats delivered in order with none duplicated.
- 64 beats of run 0 with no `hd_son_i` → 64th beat at (r7,c7) with `ct_son_o=1`; 65th beat at (r0,c0).
- Overflow: `ptr=60`, beat (5,9) → `hata_o=1`, zero at (r7,c7,son); next two beats dropped; `son` beat consumed; following beat at (r0,c0).
- `ZZ_ZERO_FILL_EN`, `BLOCK_DIM=4`, beat (3,9,son) → zeros at idx 0..2, 9 at (r2,c0), zeros at idx 4..15, `son` on (r3,c3); 16 output beats total.
- Reset asserted during DOLDUR → after the edge, all outputs 0, `hd_hazir_o` returns to 1 once `rst_i` is low, next beat (0,4) → (r0,c0,4).
